// File: rtl/intpol2_d4_seq_ctrl_if.sv
// Handshake bundle between the sequencer, the input I/Q FIFO, the interpolation
// core and the downstream I/Q FIFOs.
interface intpol2_d4_seq_ctrl_if #(
  parameter int FACTOR_WIDTH = 4
);
  logic                    fifo_empty_i;
  logic                    fifo_rd_o;
  logic                    afull_I_i;
  logic                    afull_Q_i;
  logic                    core_load_o;
  logic                    core_step_o;
  logic                    write_enable_o;
  logic [FACTOR_WIDTH-1:0] phase_o;

  modport master (
    input  fifo_empty_i, afull_I_i, afull_Q_i,
    output fifo_rd_o, core_load_o, core_step_o, write_enable_o, phase_o
  );

  modport slave (
    output fifo_empty_i, afull_I_i, afull_Q_i,
    input  fifo_rd_o, core_load_o, core_step_o, write_enable_o, phase_o
  );
endinterface

// File: rtl/intpol2_d4_seq_ctrl.sv
// Burst sequencer for the I/Q 2nd-order interpolator: pops one sample pair,
// loads the core, steps it through L phases under downstream back-pressure.
module intpol2_d4_seq_ctrl #(
  parameter int CNT_WIDTH    = 16,
  parameter int FACTOR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_WIDTH-1:0]    n_samples,
  input  logic [FACTOR_WIDTH-1:0] factor,
  input  logic                    int_clr,
  intpol2_d4_seq_ctrl_if.master   bus,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    int_req_o
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt, r_n, w_n_nxt, w_cnt_inc;
  logic [FACTOR_WIDTH-1:0] r_phase, w_phase_nxt, r_l, w_l_nxt, w_l_last;
  logic                    r_int, w_int_nxt;
  logic                    w_stall, w_step, w_done;

  assign w_stall   = bus.afull_I_i | bus.afull_Q_i;
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_l_last  = r_l - FACTOR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_phase <= '0;
      r_l     <= '0;
      r_int   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
      r_phase <= w_phase_nxt;
      r_l     <= w_l_nxt;
      r_int   <= w_int_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_phase_nxt = r_phase;
    w_l_nxt     = r_l;
    w_int_nxt   = r_int & ~int_clr;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_n_nxt     = n_samples;
            w_l_nxt     = (factor == '0) ? FACTOR_WIDTH'(1) : factor;
            w_cnt_nxt   = '0;
            w_phase_nxt = '0;
            w_state_nxt = (n_samples == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (!bus.fifo_empty_i) w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          w_phase_nxt = '0;
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!w_stall) begin
            if (r_phase == w_l_last) begin
              w_phase_nxt = '0;
              w_cnt_nxt   = w_cnt_inc;
              w_state_nxt = (w_cnt_inc == r_n) ? S_DONE : S_FETCH;
            end else begin
              w_phase_nxt = r_phase + FACTOR_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          // Setting the interrupt takes priority over a simultaneous clear.
          w_int_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are masked by abort so a cancelled burst never pops or writes again.
  assign w_step             = (r_state == S_RUN) & ~w_stall & ~abort;
  assign w_done             = (r_state == S_DONE) & ~abort;
  assign bus.fifo_rd_o      = (r_state == S_FETCH) & ~bus.fifo_empty_i & ~abort;
  assign bus.core_load_o    = (r_state == S_LOAD) & ~abort;
  assign bus.core_step_o    = w_step;
  assign bus.write_enable_o = w_step;
  assign bus.phase_o        = r_phase;
  assign busy_o             = (r_state != S_IDLE);
  assign done_o             = w_done;
  assign int_req_o          = r_int | w_done;

endmodule
